// File: rtl/friscv_cache_memfetcher.sv
// Instruction-cache block fetcher: turns prefetcher line requests into single-beat AXI4
// reads and returns each read completion to the cache as a one-cycle block write.
module friscv_cache_memfetcher #(
  parameter     NAME          = "memfetcher",
  parameter int AXI_ADDR_W    = 32,
  parameter int AXI_ID_W      = 8,
  parameter int AXI_DATA_W    = 128,
  parameter int CACHE_BLOCK_W = 128,
  parameter int OSTDREQ_NUM   = 4
)(
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     memctrl_arvalid,
  output logic                     memctrl_arready,
  input  logic [AXI_ADDR_W-1:0]    memctrl_araddr,
  input  logic [2:0]               memctrl_arprot,
  input  logic [AXI_ID_W-1:0]      memctrl_arid,
  output logic                     arvalid,
  input  logic                     arready,
  output logic [AXI_ADDR_W-1:0]    araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [2:0]               arprot,
  output logic [AXI_ID_W-1:0]      arid,
  input  logic                     rvalid,
  output logic                     rready,
  input  logic [AXI_ID_W-1:0]      rid,
  input  logic [1:0]               rresp,
  input  logic [AXI_DATA_W-1:0]    rdata,
  input  logic                     rlast,
  output logic                     mem_cpl_wr,
  output logic [AXI_ADDR_W-1:0]    mem_cpl_waddr,
  output logic [CACHE_BLOCK_W-1:0] mem_cpl_wdata,
  output logic [AXI_ID_W-1:0]      mem_cpl_rid,
  output logic                     rd_error
);

  localparam int ADDR_LSB_W = $clog2(AXI_DATA_W/8);
  localparam int PTR_W      = $clog2(OSTDREQ_NUM);
  localparam int CNT_W      = PTR_W + 1;

  typedef enum logic {AR_EMPTY, AR_PENDING} ar_state_t;

  ar_state_t               ar_state_reg, ar_state_next;
  logic                    rst_done_reg;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AXI_ADDR_W-1:0]   addr_mem [OSTDREQ_NUM];
  logic [AXI_ID_W-1:0]     id_mem   [OSTDREQ_NUM];
  logic                    rready_reg;
  logic                    table_full, table_empty;
  logic                    push, pop;
  logic [AXI_ADDR_W-1:0]   aligned_addr;
  logic [AXI_ADDR_W-1:0]   araddr_reg;
  logic [AXI_ID_W-1:0]     arid_reg;
  logic [2:0]              arprot_reg;

  assign aligned_addr = {memctrl_araddr[AXI_ADDR_W-1:ADDR_LSB_W], {ADDR_LSB_W{1'b0}}};
  assign table_full   = (count_reg == CNT_W'(OSTDREQ_NUM));
  assign table_empty  = (count_reg == '0);

  // rst_done_reg keeps the request channel closed during and right after reset
  assign memctrl_arready = rst_done_reg && ((ar_state_reg == AR_EMPTY) || arready) && !table_full;
  assign push            = memctrl_arvalid && memctrl_arready;
  assign pop             = rvalid && rready_reg;

  assign arlen   = 8'd0;
  assign arsize  = 3'(ADDR_LSB_W);
  assign arburst = 2'b01;
  assign araddr  = araddr_reg;
  assign arid    = arid_reg;
  assign arprot  = arprot_reg;
  assign rready  = rready_reg;

  always_comb begin
    ar_state_next = ar_state_reg;
    arvalid       = (ar_state_reg == AR_PENDING);
    case (ar_state_reg)
      AR_EMPTY:   if (push) ar_state_next = AR_PENDING;
      AR_PENDING: if (!push && arready) ar_state_next = AR_EMPTY;
      default:    ar_state_next = AR_EMPTY;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ar_state_reg <= AR_EMPTY;
      rst_done_reg <= 1'b0;
      araddr_reg   <= '0;
      arid_reg     <= '0;
      arprot_reg   <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rready_reg   <= 1'b0;
    end else begin
      ar_state_reg <= ar_state_next;
      rst_done_reg <= 1'b1;
      if (push) begin
        araddr_reg <= aligned_addr;
        arid_reg   <= memctrl_arid;
        arprot_reg <= memctrl_arprot;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg  <= count_next;
      // Rises only once the table has held an entry for a full cycle, drops as soon as it empties
      rready_reg <= (count_reg != '0) && (count_next != '0);
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= aligned_addr;
      id_mem[wr_ptr_reg]   <= memctrl_arid;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mem_cpl_wr    <= 1'b0;
      mem_cpl_waddr <= '0;
      mem_cpl_wdata <= '0;
      mem_cpl_rid   <= '0;
      rd_error      <= 1'b0;
    end else begin
      mem_cpl_wr <= pop;
      rd_error   <= pop && ((rid != id_mem[rd_ptr_reg]) || (rresp != 2'b00) || !rlast);
      if (pop) begin
        mem_cpl_waddr <= addr_mem[rd_ptr_reg];
        mem_cpl_wdata <= rdata;
        mem_cpl_rid   <= rid;
      end
    end
  end

`ifdef TRACE_CACHE
  always_ff @(posedge aclk) begin
    if (arvalid && arready)
      $display("[%s] %t AR addr=0x%0h id=0x%0h", NAME, $realtime, araddr, arid);
    if (mem_cpl_wr)
      $display("[%s] %t CPL addr=0x%0h id=0x%0h err=%0d", NAME, $realtime, mem_cpl_waddr, mem_cpl_rid, rd_error);
  end
`endif

endmodule

// File: tb/tb_friscv_cache_memfetcher.sv
// Scoreboard bench for friscv_cache_memfetcher: expected AR beats and completions are
// queued as stimulus is driven and compared when the DUT produces them.
module tb_friscv_cache_memfetcher;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         memctrl_arvalid, memctrl_arready;
  logic [31:0]  memctrl_araddr;
  logic [2:0]   memctrl_arprot;
  logic [7:0]   memctrl_arid;
  logic         arvalid, arready;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [2:0]   arprot;
  logic [7:0]   arid;
  logic         rvalid, rready;
  logic [7:0]   rid;
  logic [1:0]   rresp;
  logic [127:0] rdata;
  logic         rlast;
  logic         mem_cpl_wr;
  logic [31:0]  mem_cpl_waddr;
  logic [127:0] mem_cpl_wdata;
  logic [7:0]   mem_cpl_rid;
  logic         rd_error;

  typedef struct {logic [31:0] addr; logic [7:0] id; logic [2:0] prot;} ar_t;
  typedef struct {logic [31:0] addr; logic [7:0] id; logic [127:0] data; logic err;} cpl_t;

  ar_t  req_q[$];
  ar_t  ar_q[$];
  cpl_t exp_q[$];

  int n_cmp = 0, n_err = 0;
  int pulse_cnt = 0, b2b_cnt = 0, err_cnt = 0;
  logic prev_wr = 1'b0;

  always #5 aclk = ~aclk;

  friscv_cache_memfetcher dut (
    .aclk(aclk), .aresetn(aresetn),
    .memctrl_arvalid(memctrl_arvalid), .memctrl_arready(memctrl_arready),
    .memctrl_araddr(memctrl_araddr), .memctrl_arprot(memctrl_arprot), .memctrl_arid(memctrl_arid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arprot(arprot), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp), .rdata(rdata), .rlast(rlast),
    .mem_cpl_wr(mem_cpl_wr), .mem_cpl_waddr(mem_cpl_waddr), .mem_cpl_wdata(mem_cpl_wdata),
    .mem_cpl_rid(mem_cpl_rid), .rd_error(rd_error)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Checks of the AR channel and the completion port
  always @(negedge aclk) begin
    if (aresetn) begin
      if (arvalid && arready) begin
        check("ar_expected", ar_q.size() > 0, 1'b1);
        if (ar_q.size() > 0) begin
          ar_t a;
          a = ar_q.pop_front();
          check("araddr", araddr, a.addr);
          check("arid", arid, a.id);
          check("arprot", arprot, a.prot);
          check("arlen", arlen, 8'd0);
          check("arsize", arsize, 3'd4);
          check("arburst", arburst, 2'b01);
        end
      end
      if (mem_cpl_wr) begin
        pulse_cnt++;
        check("cpl_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          cpl_t c;
          c = exp_q.pop_front();
          check("cpl_waddr", mem_cpl_waddr, c.addr);
          check("cpl_rid", mem_cpl_rid, c.id);
          check("cpl_wdata", mem_cpl_wdata, c.data);
          check("cpl_rd_error", rd_error, c.err);
        end
      end
      if (rd_error) begin
        err_cnt++;
        check("err_with_wr", mem_cpl_wr, 1'b1);
      end
      if (mem_cpl_wr && prev_wr) b2b_cnt++;
      prev_wr = mem_cpl_wr;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic send_req(input logic [31:0] addr, input logic [7:0] id, input logic [2:0] prot);
    logic hs;
    ar_t a;
    memctrl_arvalid = 1'b1;
    memctrl_araddr  = addr;
    memctrl_arid    = id;
    memctrl_arprot  = prot;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      hs = memctrl_arready;
      @(posedge aclk); #1;
      if (hs) begin
        a.addr = {addr[31:4], 4'h0};
        a.id   = id;
        a.prot = prot;
        req_q.push_back(a);
        ar_q.push_back(a);
        memctrl_arvalid = 1'b0;
        $display("REQ  addr=0x%08h id=0x%02h accepted", addr, id);
        return;
      end
    end
    check("req_timeout", 1'b0, hs);
    memctrl_arvalid = 1'b0;
  endtask

  task automatic r_beat(input logic [7:0] id_in, input logic [1:0] resp_in,
                        input logic last_in, input logic [127:0] data_in);
    logic hs;
    ar_t  hd;
    cpl_t c;
    rvalid = 1'b1;
    rid    = id_in;
    rresp  = resp_in;
    rlast  = last_in;
    rdata  = data_in;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      hs = rready;
      @(posedge aclk); #1;
      if (hs) begin
        if (req_q.size() > 0) begin
          hd = req_q.pop_front();
          c.addr = hd.addr;
          c.id   = id_in;
          c.data = data_in;
          c.err  = (id_in != hd.id) || (resp_in != 2'b00) || !last_in;
          exp_q.push_back(c);
          $display("R    id=0x%02h resp=%0d last=%0d -> expect addr=0x%08h err=%0d",
                   id_in, resp_in, last_in, c.addr, c.err);
        end
        rvalid = 1'b0;
        return;
      end
    end
    check("r_timeout", 1'b0, hs);
    rvalid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge aclk);
    check({tag, "_memctrl_arready"}, memctrl_arready, 1'b0);
    check({tag, "_arvalid"}, arvalid, 1'b0);
    check({tag, "_araddr"}, araddr, 32'h0);
    check({tag, "_arid"}, arid, 8'h0);
    check({tag, "_arprot"}, arprot, 3'h0);
    check({tag, "_rready"}, rready, 1'b0);
    check({tag, "_cpl_wr"}, mem_cpl_wr, 1'b0);
    check({tag, "_cpl_waddr"}, mem_cpl_waddr, 32'h0);
    check({tag, "_cpl_wdata"}, mem_cpl_wdata, 128'h0);
    check({tag, "_cpl_rid"}, mem_cpl_rid, 8'h0);
    check({tag, "_rd_error"}, rd_error, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, b0, e0;
    aresetn = 1'b0; memctrl_arvalid = 1'b0; memctrl_araddr = '0; memctrl_arprot = '0;
    memctrl_arid = '0; arready = 1'b1; rvalid = 1'b0; rid = '0; rresp = '0; rdata = '0; rlast = 1'b1;
    cycles(3);
    check_reset_outputs("rst");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("arready_at_release", memctrl_arready, 1'b0);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("arready_after_release", memctrl_arready, 1'b1);
    @(posedge aclk); #1;

    // Single fetch
    p0 = pulse_cnt;
    send_req(32'h0000_1234, 8'h05, 3'h0);
    r_beat(8'h05, 2'b00, 1'b1, 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF);
    @(negedge aclk);
    check("single_wr_high", mem_cpl_wr, 1'b1);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("single_wr_low", mem_cpl_wr, 1'b0);
    check("single_pulses", pulse_cnt - p0, 1);
    @(posedge aclk); #1;

    // AR backpressure
    arready = 1'b0;
    p0 = pulse_cnt;
    send_req(32'h0000_2008, 8'h07, 3'h3);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bp_arvalid", arvalid, 1'b1);
      check("bp_araddr", araddr, 32'h0000_2000);
      check("bp_arid", arid, 8'h07);
      check("bp_memctrl_arready", memctrl_arready, 1'b0);
      @(posedge aclk); #1;
    end
    arready = 1'b1;
    cycles(1);
    check("bp_ar_drained", ar_q.size(), 0);
    r_beat(8'h07, 2'b00, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    cycles(2);
    check("bp_single_cpl", pulse_cnt - p0, 1);

    // Table full, then drain back-to-back
    send_req(32'h0000_0100, 8'h01, 3'h0);
    send_req(32'h0000_0110, 8'h02, 3'h0);
    send_req(32'h0000_0120, 8'h03, 3'h0);
    send_req(32'h0000_0130, 8'h04, 3'h0);
    @(negedge aclk);
    check("full_memctrl_arready", memctrl_arready, 1'b0);
    @(posedge aclk); #1;
    r_beat(8'h01, 2'b00, 1'b1, 128'hA0);
    @(negedge aclk);
    check("full_pop_wr", mem_cpl_wr, 1'b1);
    check("full_pop_addr", mem_cpl_waddr, 32'h0000_0100);
    check("full_arready_back", memctrl_arready, 1'b1);
    @(posedge aclk); #1;
    b0 = b2b_cnt;
    r_beat(8'h02, 2'b00, 1'b1, 128'hA1);
    r_beat(8'h03, 2'b00, 1'b1, 128'hA2);
    r_beat(8'h04, 2'b00, 1'b1, 128'hA3);
    @(negedge aclk);
    check("drain_rready_low", rready, 1'b0);
    @(posedge aclk); #1;
    check("drain_b2b", b2b_cnt - b0, 2);

    // Two requests, back-to-back completions
    send_req(32'h0000_4000, 8'h11, 3'h0);
    send_req(32'h0000_4010, 8'h12, 3'h0);
    cycles(2);
    b0 = b2b_cnt;
    r_beat(8'h11, 2'b00, 1'b1, $urandom());
    r_beat(8'h12, 2'b00, 1'b1, {$urandom(), $urandom(), $urandom(), $urandom()});
    @(negedge aclk);
    check("b2b_rready_low", rready, 1'b0);
    @(posedge aclk); #1;
    check("b2b_pulses", b2b_cnt - b0, 1);

    // Error responses
    e0 = err_cnt;
    send_req(32'h0000_5000, 8'h21, 3'h0);
    send_req(32'h0000_5010, 8'h22, 3'h0);
    send_req(32'h0000_5020, 8'h23, 3'h0);
    cycles(2);
    r_beat(8'h21, 2'b10, 1'b1, 128'hE0);
    r_beat(8'h99, 2'b00, 1'b1, 128'hE1);
    r_beat(8'h23, 2'b00, 1'b0, 128'hE2);
    @(negedge aclk);
    check("err_rready_low", rready, 1'b0);
    @(posedge aclk); #1;
    check("err_count", err_cnt - e0, 3);

    // Reset with requests in flight (last one still held on AR)
    send_req(32'h0000_6000, 8'h31, 3'h0);
    send_req(32'h0000_6010, 8'h32, 3'h0);
    cycles(1);
    arready = 1'b0;
    send_req(32'h0000_6020, 8'h33, 3'h5);
    cycles(1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    req_q.delete(); ar_q.delete(); exp_q.delete();
    arready = 1'b1;
    check_reset_outputs("midrst");
    @(posedge aclk); #1;
    p0 = pulse_cnt;
    rvalid = 1'b1; rid = 8'h31; rresp = 2'b00; rlast = 1'b1; rdata = 128'hBAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("stale_rready", rready, 1'b0);
      check("stale_cpl_wr", mem_cpl_wr, 1'b0);
      @(posedge aclk); #1;
    end
    rvalid = 1'b0;
    cycles(1);
    check("stale_no_pulse", pulse_cnt - p0, 0);
    @(negedge aclk);
    check("post_rst_arready", memctrl_arready, 1'b1);
    check("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
